mem_stage_mc: RTL and testbench
===============================

Name: mem_stage_mc

Overview:
- Parametrised, multi-cycle memory stage for the 5-stage Y86-64 pipeline, sitting between execute/memory pipeline register (M_*) and write-back register (W_*).
- Replaces the single-cycle combinational data memory: synchronous writes, configurable access latency with a stall handshake, bounds checking producing SADR, and registered m_* outputs.
- Non-memory instructions pass through in one cycle.

Parameters:
- DATA_W, 64, data word width in bits.
- DEPTH, 1024, number of DATA_W words in the data memory.
- LATENCY, 1, cycles from acceptance to result (>=1).
- INIT_WORD, 64'd2, simulation initial value of every memory word.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- M_valid  in  1  M register holds a live instruction.
- M_stat  in  3  incoming status (AOK=1, HLT=2, ADR=3, INS=4).
- M_icode  in  4  instruction code.
- M_valA  in  DATA_W  store data, or address for ret/popq.
- M_valE  in  DATA_W  address for rmmovq/mrmovq/call/pushq; passed through.
- mem_stall  out  1  combinational; upstream must hold M_* stable while high.
- m_valid  out  1  registered; m_* valid this cycle.
- m_stat  out  3  registered status.
- m_icode  out  4  registered icode.
- m_valM  out  DATA_W  registered read data.
- m_valE  out  DATA_W  registered copy of M_valE.

Behaviour:
- Reset: m_valid=0, m_stat=AOK, m_icode=0 (nop), m_valM=0, m_valE=0, FSM=IDLE, counter=0. Memory contents are not reset; they are set to INIT_WORD at time zero.
- Op classes:
  - Reads: mrmovq (5), popq (B) use address valE/valA as listed below; ret (9) uses valA.
  - Writes: rmmovq (4), call (8), pushq (A); all write M_valA.
  - Address sources: mrmovq, rmmovq, call, pushq use M_valE; popq and ret use M_valA.
  - All other icodes: non-memory.
- Addressing: byte address; word index = addr[.. :3]. Out of range when addr >= DEPTH*8.
- An op is "live" when M_valid=1, it is a memory op, M_stat=AOK, and the address is in range.
- FSM states: IDLE, BUSY.
  - IDLE, live op, LATENCY=1: complete at next edge. mem_stall=0.
  - IDLE, live op, LATENCY>1: mem_stall=1. Go to BUSY with counter=1.
  - BUSY: mem_stall=1 while counter<LATENCY-1; counter increments each cycle.
  - BUSY, counter=LATENCY-1: mem_stall=0. Complete at next edge, then return to IDLE.
- Completion edge:
  - Writes commit to memory.
  - Reads sample memory into m_valM.
  - m_valid=1; m_stat, m_icode, m_valE copied from the M_* inputs.
- Non-memory op, or M_stat != AOK:
  - Single cycle, no stall, no write.
  - m_valM=0; m_stat=M_stat passed unchanged.
- Out-of-range address on a memory op with AOK status:
  - Single cycle, no stall, no write, m_valM=0, m_stat=ADR.
- M_valid=0 in IDLE: m_valid=0 next cycle; other m_* registers hold their values.
- Read-after-write: a read completing on the cycle after a write to the same word returns the new data.
- Total latency for a live op is LATENCY cycles from first presentation to m_valid.
- Reset mid-BUSY: FSM returns to IDLE immediately. The pending write is discarded; memory is not modified.
- mem_stall is never asserted in reset, in IDLE with no live op, or when LATENCY=1.

Optional Feature:
- MEM_ALIGN_CHECK_EN defined: a memory op with addr[2:0] != 0 is treated like out-of-range (m_stat=ADR, no write, no stall).
- Undefined: addr[2:0] is ignored and the access goes to the containing word.

Decomposition:
- Package y86_pkg holds:
  - icode localparams: IRMMOVQ=4, IMRMOVQ=5, ICALL=8, IRET=9, IPUSHQ=A, IPOPQ=B, INOP=1.
  - Stat localparams: SAOK=1, SHLT=2, SADR=3, SINS=4.
  - Helper functions is_mem_read / is_mem_write.
- Sub-module mem_array: DEPTH x DATA_W storage with synchronous write port, asynchronous read port, and INIT_WORD initialisation. mem_stage_mc holds the FSM, checks, and output registers.

Test Plan:
- LATENCY=1; rmmovq M_valA=0x1234, M_valE=0x40; then mrmovq M_valE=0x40 -> second op m_valM=0x1234, m_stat=1, mem_stall never high.
- LATENCY=3; mrmovq from untouched word 0x80 -> mem_stall high 2 cycles, m_valid on third edge, m_valM=2.
- pushq M_valE=0x1F8, M_valA=0xAB; then popq M_valA=0x1F8 -> m_valM=0xAB; ret M_valA=0x1F8 -> m_valM=0xAB.
- rmmovq M_valE=0x2000 (DEPTH=1024) -> m_stat=3, no stall, word 0 unchanged (read back gives 2). Also M_stat=4 rmmovq in range -> no write, m_stat=4.
- LATENCY=4; assert rst during second BUSY cycle of rmmovq to 0x10 -> outputs at reset values, mem_stall=0, later read of 0x10 returns 2.
- With MEM_ALIGN_CHECK_EN, mrmovq M_valE=0x43 -> m_stat=3. Without the macro -> m_valM = word at 0x40.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and memory-op classification for the memory stage.
package y86_pkg;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    typedef enum logic {IDLE, BUSY} state_t;

    function automatic logic is_mem_read(input logic [3:0] icode);
        return (icode == IMRMOVQ) || (icode == IRET) || (icode == IPOPQ);
    endfunction

    function automatic logic is_mem_write(input logic [3:0] icode);
        return (icode == IRMMOVQ) || (icode == ICALL) || (icode == IPUSHQ);
    endfunction

    // popq/ret address through the stack pointer copy in valA
    function automatic logic addr_from_vala(input logic [3:0] icode);
        return (icode == IRET) || (icode == IPOPQ);
    endfunction
endpackage

// File: rtl/mem_stage_mc_mem_array.sv
// Data memory: synchronous write, asynchronous read, every word preset to INIT_WORD.
module mem_array #(
    parameter int                DATA_W    = 64,
    parameter int                DEPTH     = 1024,
    parameter logic [DATA_W-1:0] INIT_WORD = DATA_W'(2),
    parameter int                AW        = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH] = '{default: INIT_WORD};

    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wdata;
    end

    assign rdata = mem[idx];
endmodule

// File: rtl/mem_stage_mc.sv
// Multi-cycle Y86-64 memory stage with latency stall and bounds checks.
// Define MEM_ALIGN_CHECK_EN to also fault misaligned (addr[2:0] != 0) accesses.
module mem_stage_mc
    import y86_pkg::*;
#(
    parameter int                DATA_W    = 64,
    parameter int                DEPTH     = 1024,
    parameter int                LATENCY   = 1,
    parameter logic [DATA_W-1:0] INIT_WORD = DATA_W'(2)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              M_valid,
    input  logic [2:0]        M_stat,
    input  logic [3:0]        M_icode,
    input  logic [DATA_W-1:0] M_valA,
    input  logic [DATA_W-1:0] M_valE,
    output logic              mem_stall,
    output logic              m_valid,
    output logic [2:0]        m_stat,
    output logic [3:0]        m_icode,
    output logic [DATA_W-1:0] m_valM,
    output logic [DATA_W-1:0] m_valE
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY + 1);
    localparam logic [DATA_W-1:0] LIMIT = DATA_W'(DEPTH) << 3;

    state_t            state, state_nx;
    logic [CW-1:0]     cnt, cnt_nx;
    logic              rd, wr, mem_op, bad, live, we;
    logic [DATA_W-1:0] addr, rdata;

    assign rd     = is_mem_read(M_icode);
    assign wr     = is_mem_write(M_icode);
    assign mem_op = rd | wr;
    assign addr   = addr_from_vala(M_icode) ? M_valA : M_valE;
`ifdef MEM_ALIGN_CHECK_EN
    assign bad    = (addr >= LIMIT) || (addr[2:0] != 3'd0);
`else
    assign bad    = (addr >= LIMIT);
`endif
    assign live   = M_valid && mem_op && (M_stat == SAOK) && !bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        mem_stall = 1'b0;
        case (state)
            IDLE: if (live && LATENCY > 1) begin
                mem_stall = 1'b1;
                state_nx  = BUSY;
                cnt_nx    = CW'(1);
            end
            BUSY: if (cnt < CW'(LATENCY - 1)) begin
                mem_stall = 1'b1;
                cnt_nx    = cnt + 1'b1;
            end else begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
            default: state_nx = IDLE;
        endcase
        if (rst) mem_stall = 1'b0;
    end

    // rst gating keeps an in-flight store from landing while reset is held
    assign we = live && wr && !mem_stall && !rst;

    mem_array #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .INIT_WORD(INIT_WORD)
    ) u_mem (
        .clk(clk), .we(we), .idx(addr[AW+2:3]), .wdata(M_valA), .rdata(rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_stat  <= SAOK;
            m_icode <= 4'h0;
            m_valM  <= '0;
            m_valE  <= '0;
        end else if (mem_stall) begin
            m_valid <= 1'b0;
        end else if (M_valid) begin
            m_valid <= 1'b1;
            m_icode <= M_icode;
            m_valE  <= M_valE;
            m_stat  <= (mem_op && M_stat == SAOK && bad) ? SADR : M_stat;
            m_valM  <= (live && rd) ? rdata : '0;
        end else begin
            m_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mem_stage_mc.sv
// Directed + random checks of mem_stage_mc at LATENCY 1, 3 and 4 against a word-level model.
module tb_mem_stage_mc;
    logic        clk = 1'b0;
    logic        rst     [3];
    logic        M_valid [3];
    logic [2:0]  M_stat  [3];
    logic [3:0]  M_icode [3];
    logic [63:0] M_valA  [3];
    logic [63:0] M_valE  [3];
    logic        mem_stall [3];
    logic        m_valid [3];
    logic [2:0]  m_stat  [3];
    logic [3:0]  m_icode [3];
    logic [63:0] m_valM  [3];
    logic [63:0] m_valE  [3];

    int cmp = 0;
    int errs = 0;

    logic [63:0] mdl [longint];
    logic        ev   [3];
    logic [2:0]  est  [3];
    logic [3:0]  eic  [3];
    logic [63:0] evM  [3];
    logic [63:0] evE  [3];

    always #5 clk = ~clk;

    mem_stage_mc #(.LATENCY(1)) dut0 (
        .clk(clk), .rst(rst[0]), .M_valid(M_valid[0]), .M_stat(M_stat[0]), .M_icode(M_icode[0]),
        .M_valA(M_valA[0]), .M_valE(M_valE[0]), .mem_stall(mem_stall[0]), .m_valid(m_valid[0]),
        .m_stat(m_stat[0]), .m_icode(m_icode[0]), .m_valM(m_valM[0]), .m_valE(m_valE[0]));
    mem_stage_mc #(.LATENCY(3)) dut1 (
        .clk(clk), .rst(rst[1]), .M_valid(M_valid[1]), .M_stat(M_stat[1]), .M_icode(M_icode[1]),
        .M_valA(M_valA[1]), .M_valE(M_valE[1]), .mem_stall(mem_stall[1]), .m_valid(m_valid[1]),
        .m_stat(m_stat[1]), .m_icode(m_icode[1]), .m_valM(m_valM[1]), .m_valE(m_valE[1]));
    mem_stage_mc #(.LATENCY(4)) dut2 (
        .clk(clk), .rst(rst[2]), .M_valid(M_valid[2]), .M_stat(M_stat[2]), .M_icode(M_icode[2]),
        .M_valA(M_valA[2]), .M_valE(M_valE[2]), .mem_stall(mem_stall[2]), .m_valid(m_valid[2]),
        .m_stat(m_stat[2]), .m_icode(m_icode[2]), .m_valM(m_valM[2]), .m_valE(m_valE[2]));

    function automatic int lat(input int k);
        return (k == 0) ? 1 : (k == 1) ? 3 : 4;
    endfunction

    function automatic longint key(input int k, input logic [63:0] addr);
        return (longint'(k) << 40) | longint'(addr >> 3);
    endfunction

    function automatic logic [63:0] mrd(input int k, input logic [63:0] addr);
        longint kk = key(k, addr);
        return mdl.exists(kk) ? mdl[kk] : 64'd2;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cmp++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_reset_exp(input int k);
        ev[k] = 1'b0; est[k] = 3'd1; eic[k] = 4'h0; evM[k] = '0; evE[k] = '0;
    endtask

    task automatic chk_out(input int k, input string tag);
        chk({tag, ".valid"}, 64'(m_valid[k]), 64'(ev[k]));
        chk({tag, ".stat"},  64'(m_stat[k]),  64'(est[k]));
        chk({tag, ".icode"}, 64'(m_icode[k]), 64'(eic[k]));
        chk({tag, ".valM"},  m_valM[k], evM[k]);
        chk({tag, ".valE"},  m_valE[k], evE[k]);
    endtask

    // Caller is at posedge+1; on return the op has completed and outputs were checked.
    task automatic do_op(input int k, input logic v, input logic [2:0] st, input logic [3:0] ic,
                         input logic [63:0] a, input logic [63:0] e, input string tag);
        logic memop, rdop, wrop, bad, live;
        logic [63:0] ad;
        int stalls, exp_st;
        rdop  = (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
        wrop  = (ic == 4'h4) || (ic == 4'h8) || (ic == 4'hA);
        memop = rdop || wrop;
        ad    = (ic == 4'h9 || ic == 4'hB) ? a : e;
        bad   = ad >= 64'd8192;
`ifdef MEM_ALIGN_CHECK_EN
        if (ad[2:0] != 3'd0) bad = 1'b1;
`endif
        live   = v && memop && st == 3'd1 && !bad;
        exp_st = live ? lat(k) - 1 : 0;
        if (v) begin
            ev[k]  = 1'b1;
            est[k] = (memop && st == 3'd1 && bad) ? 3'd3 : st;
            eic[k] = ic;
            evE[k] = e;
            evM[k] = (live && rdop) ? mrd(k, ad) : 64'd0;
        end else begin
            ev[k] = 1'b0;
        end
        if (live && wrop) mdl[key(k, ad)] = a;

        M_valid[k] = v; M_stat[k] = st; M_icode[k] = ic; M_valA[k] = a; M_valE[k] = e;
        #1;
        stalls = 0;
        while (mem_stall[k] === 1'b1 && stalls < 16) begin
            stalls++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        chk({tag, ".stalls"}, 64'(stalls), 64'(exp_st));
        chk_out(k, tag);
        M_valid[k] = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; M_valid[k] = 1'b0; M_stat[k] = 3'd1; M_icode[k] = 4'h0;
            M_valA[k] = '0; M_valE[k] = '0;
            set_reset_exp(k);
        end
        // a live store held during reset must neither stall nor write
        M_valid[1] = 1'b1; M_icode[1] = 4'h4; M_valE[1] = 64'h80; M_valA[1] = 64'hDEAD;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk_out(k, "reset");
            chk("reset.stall", 64'(mem_stall[k]), 64'd0);
        end
        M_valid[1] = 1'b0;
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
        @(posedge clk); #1;

        do_op(0, 1, 1, 4'h4, 64'h1234, 64'h40, "l1_rmmov");
        do_op(0, 1, 1, 4'h5, 64'h0, 64'h40, "l1_raw");
        do_op(1, 1, 1, 4'h5, 64'h0, 64'h80, "l3_mrmov");
        do_op(0, 1, 1, 4'hA, 64'hAB, 64'h1F8, "push");
        do_op(0, 1, 1, 4'hB, 64'h1F8, 64'h200, "pop");
        do_op(0, 1, 1, 4'h9, 64'h1F8, 64'h200, "ret");
        do_op(0, 1, 1, 4'h4, 64'h99, 64'h2000, "oor_wr");
        do_op(0, 1, 1, 4'h5, 64'h0, 64'h0, "word0");
        do_op(0, 1, 4, 4'h4, 64'h77, 64'h8, "ins_wr");
        do_op(0, 1, 1, 4'h5, 64'h0, 64'h8, "word1");
        do_op(1, 1, 1, 4'h8, 64'hC0FFEE, 64'h1FF8, "last_wr");
        do_op(1, 1, 1, 4'h5, 64'h0, 64'h1FF8, "last_rd");
        do_op(1, 1, 1, 4'h5, 64'h0, 64'h2000, "first_oor");
        do_op(0, 1, 1, 4'h5, 64'h0, 64'h43, "misalign");
        do_op(0, 1, 1, 4'h6, 64'h5, 64'h77, "opq");
        do_op(0, 0, 1, 4'h5, 64'h0, 64'h40, "bubble");

        // reset during the second BUSY cycle of a store on the LATENCY=4 stage
        M_valid[2] = 1'b1; M_stat[2] = 3'd1; M_icode[2] = 4'h4; M_valA[2] = 64'h55; M_valE[2] = 64'h10;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst[2] = 1'b1;
        #1;
        set_reset_exp(2);
        chk_out(2, "midbusy_rst");
        chk("midbusy_rst.stall", 64'(mem_stall[2]), 64'd0);
        M_valid[2] = 1'b0;
        @(posedge clk); #1;
        rst[2] = 1'b0;
        do_op(2, 1, 1, 4'h5, 64'h0, 64'h10, "after_rst");

        for (int n = 0; n < 60; n++) begin
            int k, r;
            logic v;
            logic [2:0] st;
            logic [3:0] ic;
            logic [63:0] ad, dat;
            k   = $urandom_range(0, 2);
            v   = $urandom_range(0, 7) != 0;
            ic  = 4'($urandom_range(0, 11));
            st  = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
            r   = $urandom_range(0, 9);
            if (r == 0)      ad = 64'h2000 + 64'($urandom_range(0, 1000)) * 8;
            else if (r == 1) ad = 64'($urandom_range(0, 31)) * 8 + 64'($urandom_range(1, 7));
            else if (r == 2) ad = 64'h1FF8;
            else             ad = 64'($urandom_range(0, 31)) * 8;
            dat = {$urandom, $urandom};
            if (ic == 4'h9 || ic == 4'hB) do_op(k, v, st, ic, ad, dat, "rand");
            else                          do_op(k, v, st, ic, dat, ad, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end
endmodule
